// File: rtl/i2s_tx_sample_buffer.sv
// First-word-fall-through sample FIFO that feeds an I2S transmitter.
// It adds a hysteresis start flag and underrun detection and counting.
module i2s_tx_sample_buffer #(
  parameter  int DEPTH   = 64,
  parameter  int HIGH_WM = 32,
  localparam int LW      = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic [23:0]   wr_data_i,
  input  logic          wr_valid_i,
  output logic          wr_ready_o,
  output logic [23:0]   ram_data_o,
  output logic          ram_valid_o,
  input  logic          ram_ready_i,
  output logic          buffer_ready_o,
  output logic [LW-1:0] level_o,
  output logic          underrun_o,
  output logic [15:0]   underrun_cnt_o
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {ST_IDLE, ST_ARMED} st_e;

  logic [23:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          r_underrun;
  logic [15:0]   r_underrun_cnt;
  st_e           r_state, w_state_nxt;

  logic w_push, w_pop, w_underrun;

  assign wr_ready_o     = (r_level < LW'(DEPTH));
  assign ram_valid_o    = (r_level != '0);
  assign ram_data_o     = ram_valid_o ? r_mem[r_rd_ptr] : 24'h000000;
  assign level_o        = r_level;
  assign buffer_ready_o = (r_state == ST_ARMED);
  assign underrun_o     = r_underrun;
  assign underrun_cnt_o = r_underrun_cnt;

  // A flush discards any push or pop in its cycle. An underrun is not a pop,
  // so it is still counted.
  assign w_push     = wr_valid_i & wr_ready_o & ~flush_i;
  assign w_pop      = ram_ready_i & ram_valid_o & ~flush_i;
  assign w_underrun = ram_ready_i & ~ram_valid_o;

  // Sample storage is left unreset. Reads are masked while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_underrun     <= 1'b0;
      r_underrun_cnt <= '0;
    end else begin
      r_underrun <= w_underrun;
      if (w_underrun && (r_underrun_cnt != 16'hFFFF))
        r_underrun_cnt <= r_underrun_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // The flag arms and disarms from the registered level, so it lags it by one edge.
  always_comb begin
    w_state_nxt = r_state;
    if (flush_i) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (r_level >= LW'(HIGH_WM)) w_state_nxt = ST_ARMED;
        ST_ARMED: if (r_level == '0)           w_state_nxt = ST_IDLE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/i2s_tx_sample_buffer.md
I2S_TX_SAMPLE_BUFFER -- requirements
Module: i2s_tx_sample_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 64, meaning sample storage capacity in 24-bit words; power of two, 4 to 1024.
REQ-002 The block SHALL have parameter HIGH_WM, default 32, meaning the fill level that arms buffer_ready_o; range 1 to DEPTH.
REQ-003 The block SHALL have port clk_i, input, 1, meaning the system clock.
REQ-004 The block SHALL have port rst_ni, input, 1, meaning reset; it is asynchronous and active-low.
REQ-005 The block SHALL have port flush_i, input, 1, meaning a synchronous clear of stored samples.
REQ-006 The block SHALL have port wr_data_i, input, 24, meaning the signed sample from the producer.
REQ-007 The block SHALL have port wr_valid_i, input, 1, meaning wr_data_i is valid.
REQ-008 The block SHALL have port wr_ready_o, output, 1, meaning the buffer accepts a write this cycle.
REQ-009 The block SHALL have port ram_data_o, output, 24, meaning the head sample to the I2S transmitter.
REQ-010 The block SHALL have port ram_valid_o, output, 1, meaning ram_data_o holds a valid head sample.
REQ-011 The block SHALL have port ram_ready_i, input, 1, meaning a one-cycle sample request pulse from the transmitter.
REQ-012 The block SHALL have port buffer_ready_o, output, 1, meaning enough data is buffered to start transmission.
REQ-013 The block SHALL have port level_o, output, clog2(DEPTH+1), meaning the current stored word count.
REQ-014 The block SHALL have port underrun_o, output, 1, meaning a one-cycle pulse when a request finds the buffer empty.
REQ-015 The block SHALL have port underrun_cnt_o, output, 16, meaning the saturating count of underruns.

Function
REQ-016 Storage SHALL be a first-word-fall-through FIFO: ram_data_o and ram_valid_o SHALL reflect the oldest stored word combinationally from registered state, with zero-cycle request-to-data latency.
REQ-017 ram_valid_o SHALL equal (level_o != 0); ram_data_o SHALL be 24'h000000 whenever ram_valid_o is 0.
REQ-018 A pop SHALL occur on a clk_i edge with ram_ready_i=1 and ram_valid_o=1; the next word SHALL appear on ram_data_o on the following cycle.
REQ-019 A push SHALL occur on a clk_i edge with wr_valid_i=1 and wr_ready_o=1; wr_ready_o SHALL equal (level_o < DEPTH).
REQ-020 wr_ready_o SHALL depend only on the current level, not on ram_ready_i: when full, a simultaneous pop SHALL NOT enable a same-cycle push.
REQ-021 For a simultaneous push and pop, level_o SHALL be unchanged and both operations SHALL take effect.
REQ-022 Read and write pointers SHALL wrap modulo DEPTH; level_o SHALL range 0..DEPTH inclusive.
REQ-023 Writing to a full buffer (wr_valid_i=1, wr_ready_o=0) SHALL be ignored; stored data and level SHALL be unchanged.
REQ-024 buffer_ready_o SHALL be a registered hysteresis flag with two states, IDLE and ARMED.
REQ-025 buffer_ready_o SHALL go IDLE->ARMED on the edge after level_o reaches HIGH_WM or more.
REQ-026 buffer_ready_o SHALL go ARMED->IDLE on the edge after level_o reaches 0, or on flush_i.
REQ-027 A request with ram_ready_i=1 and ram_valid_o=0 SHALL pulse underrun_o for exactly one cycle on the following cycle, SHALL leave the pointers untouched, and SHALL increment underrun_cnt_o, saturating at 16'hFFFF.
REQ-028 flush_i=1 SHALL, on that edge, zero both pointers and level_o and force buffer_ready_o to 0; any push or pop in that cycle SHALL be discarded; underrun_cnt_o SHALL be retained.

Reset
REQ-029 While rst_ni=0, all state SHALL clear asynchronously: level_o=0, ram_valid_o=0, ram_data_o=0, wr_ready_o=1, buffer_ready_o=0, underrun_o=0, underrun_cnt_o=0, and both pointers=0.
REQ-030 Stored word contents need no reset; ram_data_o SHALL still read 0 while empty.
REQ-031 Reset asserted mid-operation SHALL abandon all stored samples; the first cycle after deassertion SHALL behave as an empty buffer.

Verification
REQ-032 Test: push 32 samples 0x000001..0x000020 with no requests -> level_o=32, buffer_ready_o=1 one cycle later, ram_data_o=0x000001.
REQ-033 Test: from that state, 32 request pulses -> ram_data_o sequence 0x000001..0x000020 in order, each sample sampled in its pulse cycle; after the last, ram_valid_o=0 and buffer_ready_o=0 one cycle later.
REQ-034 Test: fill to 64 with DEPTH=64 -> wr_ready_o=0; extra write 0xABCDEF is ignored; simultaneous pop plus write -> level_o=63 and the write is not stored.
REQ-035 Test: request pulse while empty, repeated 3 times -> three one-cycle underrun_o pulses, underrun_cnt_o=3, level_o=0.
REQ-036 Test: wrap-around, 200 interleaved pushes and pops of an incrementing pattern -> output equals input order with no gaps or duplicates.
REQ-037 Test: flush_i during a simultaneous push and pop at level 10, then rst_ni low mid-stream -> level_o=0 and ram_valid_o=0 immediately; underrun_cnt_o retained across the flush but cleared by the reset.
